// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the SRAM port arbiter: default geometry of the
//   128b x 2048 activation/psum macro, the controller state encoding and the
//   request op encoding.
//   No ports (package).
package sram_ctrl_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 128;

  // Controller states. RD/RC form the read access; W0..W2 the write access.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RC   = 3'd2,
    ST_W0   = 3'd3,
    ST_W1   = 3'd4,
    ST_W2   = 3'd5
  } state_t;

  // Request op as carried on req_we / rsp_we.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Request/response bundle between the requesters (L0, OFIFO, psum writeback)
//   and the SRAM port arbiter.
//   Signals:
//     req_valid [NUM_REQ]          request valid per requester
//     req_ready [NUM_REQ]          request accepted (one-hot or zero)
//     req_we    [NUM_REQ]          1 = write, 0 = read
//     req_addr  [NUM_REQ*ADDR_W]   requester i at [i*ADDR_W +: ADDR_W]
//     req_wdata [NUM_REQ*DATA_W]   requester i at [i*DATA_W +: DATA_W]
//     rsp_valid                    one-cycle response pulse
//     rsp_id    [ID_W]             requester owning the response
//     rsp_we                       1 = write ack, 0 = read data
//     rsp_rdata [DATA_W]           read data, held until the next read response
//   Modports: master (requester side), slave (arbiter side).
//
// Handshake: a requester raises req_valid[i] together with req_we/addr/wdata
// and holds all of them stable until it sees req_ready[i]. A request is
// accepted at the rising edge where req_valid[i] & req_ready[i] are both high.
// req_ready is combinational and may only rise while the arbiter is idle; it
// never backs up a response, which is a plain pulse with no ready.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 128
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic                      rsp_we;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_we, rsp_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Picks one requester out of a request vector.
//   Default: round-robin, the first requester after the last granted one wins
//   (wrapping); the pointer moves only when 'advance' reports an accept. After
//   reset the pointer sits at NUM_REQ-1 so requester 0 wins first.
//   With ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and the
//   pointer register does not exist.
//   Ports:
//     clk      in   clock
//     rst_n    in   asynchronous active-low reset
//     req      in   [NUM_REQ] request vector
//     advance  in   the current grant was accepted this cycle
//     grant    out  [NUM_REQ] one-hot grant, zero when no request
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

`ifdef ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, advance};

  // Scan from the top down so the lowest requesting index is left standing.
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

`else

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] sel;
  logic             found;
  int               idx;

  // Walk NUM_REQ slots starting just after the pointer; first hit wins.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = ptr;
    idx     = 0;
    sel     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        win_idx    = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PTR_W'(NUM_REQ - 1);
    end else if (advance && found) begin
      ptr <= win_idx;
    end
  end

`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port 128b x 2048 activation/psum SRAM macro between
//   NUM_REQ requesters. Requests arrive on valid/ready channels, are arbitrated
//   (round-robin by default, fixed priority when ARB_FIXED_PRIO_EN is defined),
//   and sequenced onto the macro pins; a shared response pulse returns read
//   data or a write ack tagged with the requester id.
//   Access timing (all macro pins registered):
//     read : RD (cen=0, ren=1) -> RC (cen=1, capture q at end) -> response
//     write: W0, W1 (cen=0, wen=0) -> W2 (cen=0, wen=1, commit) -> response
//   Ports:
//     CLK        in   clock, all logic on posedge
//     RESET_N    in   asynchronous active-low reset
//     bus        slave modport of sram_port_arbiter_if (requests/response)
//     sram_cen   out  macro chip enable, active low
//     sram_wen   out  macro write enable, active high, only in W2
//     sram_ren   out  macro read enable, high during RD
//     sram_a     out  [ADDR_W] macro address, holds when idle
//     sram_d     out  [DATA_W] macro write data, holds when idle
//     sram_q     in   [DATA_W] macro read data
//     dbg_state  out  current controller state
module sram_port_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  sram_port_arbiter_if.slave bus,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output state_t            dbg_state
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  grant;
  logic                accept;

  logic [ID_W-1:0]     grant_id;
  op_t                 grant_op;
  logic [ADDR_W-1:0]   grant_addr;
  logic [DATA_W-1:0]   grant_wdata;

  logic [ID_W-1:0]     id_q, id_n;
  logic                cen_n, wen_n, ren_n;
  logic [ADDR_W-1:0]   a_n;
  logic [DATA_W-1:0]   d_n;

  logic                rsp_valid_q, rsp_valid_n;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_n;
  logic                rsp_we_q, rsp_we_n;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // The arbiter only looks at valids, so a grant is always for a valid
  // requester; it turns into ready only while the macro is free.
  assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
  assign accept        = (state == ST_IDLE) && (grant != '0);

  // Steer the granted requester's fields.
  always_comb begin
    grant_id    = '0;
    grant_op    = OP_READ;
    grant_addr  = '0;
    grant_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id    = ID_W'(i);
        grant_op    = op_t'(bus.req_we[i]);
        grant_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        grant_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state plus next values of every registered output. The macro pin
  // values computed here are the ones that will be seen during the next
  // state, which is why e.g. wen is raised on the W1 -> W2 transition.
  always_comb begin
    state_n     = state;
    id_n        = id_q;
    cen_n       = 1'b1;
    wen_n       = 1'b0;
    ren_n       = 1'b0;
    a_n         = sram_a;
    d_n         = sram_d;
    rsp_valid_n = 1'b0;
    rsp_id_n    = rsp_id_q;
    rsp_we_n    = rsp_we_q;
    rsp_rdata_n = rsp_rdata_q;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          id_n  = grant_id;
          a_n   = grant_addr;
          cen_n = 1'b0;
          if (grant_op == OP_WRITE) begin
            state_n = ST_W0;
            d_n     = grant_wdata;
          end else begin
            state_n = ST_RD;
            ren_n   = 1'b1;
          end
        end
      end
      ST_RD: begin
        state_n = ST_RC;
      end
      ST_RC: begin
        // Macro launched q at the end of RD; it is stable through RC.
        state_n     = ST_IDLE;
        rsp_valid_n = 1'b1;
        rsp_id_n    = id_q;
        rsp_we_n    = OP_READ;
        rsp_rdata_n = sram_q;
      end
      ST_W0: begin
        state_n = ST_W1;
        cen_n   = 1'b0;
      end
      ST_W1: begin
        state_n = ST_W2;
        cen_n   = 1'b0;
        wen_n   = 1'b1;
      end
      ST_W2: begin
        // wen drops here: the macro keeps CEN low internally for two more
        // edges, so wen must never linger past the committing edge.
        state_n     = ST_IDLE;
        rsp_valid_n = 1'b1;
        rsp_id_n    = id_q;
        rsp_we_n    = OP_WRITE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Async reset pulls wen low immediately, so a write caught in W2 never
  // commits, and a read in flight never produces a response.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      id_q        <= '0;
      sram_cen    <= 1'b1;
      sram_wen    <= 1'b0;
      sram_ren    <= 1'b0;
      sram_a      <= '0;
      sram_d      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_n;
      id_q        <= id_n;
      sram_cen    <= cen_n;
      sram_wen    <= wen_n;
      sram_ren    <= ren_n;
      sram_a      <= a_n;
      sram_d      <= d_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_id_q    <= rsp_id_n;
      rsp_we_q    <= rsp_we_n;
      rsp_rdata_q <= rsp_rdata_n;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Bench for sram_port_arbiter with a behavioural model of the SRAM macro.
//   Stimulus feeds per-requester request queues; the reference model decides
//   arbitration order, availability and response timing from the access rules
//   and pushes expected responses into exp_q, which a separate monitor pops
//   whenever rsp_valid is seen. Build with ARB_FIXED_PRIO_EN to check the
//   fixed-priority variant.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  import sram_ctrl_pkg::*;

  localparam int N      = 2;
  localparam int AW     = 11;
  localparam int DW     = 128;
  localparam int STIM_W = 1 + AW + DW;       // {we, addr, data}
  localparam int EXP_W  = 32 + 8 + 1 + DW;   // {due_cycle, id, we, data}

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- DUT + macro model ----------------
  sram_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          sram_cen, sram_wen, sram_ren;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d, sram_q;
  state_t        dbg_state;

  sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_ren  (sram_ren),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q),
    .dbg_state (dbg_state)
  );

  bit [DW-1:0] sram_mem [0:2047];
  always @(posedge CLK) begin
    if (!sram_cen && sram_wen) sram_mem[sram_a] <= sram_d;
    if (!sram_cen && sram_ren) sram_q <= sram_mem[sram_a];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int due, input int id, input logic we, input logic [DW-1:0] data);
    exp_q.push_back({32'(due), 8'(id), we, data});
  endtask

  // Response monitor
  logic [EXP_W-1:0] mon_e;
  logic [DW-1:0]    last_rd = '0;
  always @(negedge CLK) begin
    if (!RESET_N) begin
      last_rd = '0;
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: actual rsp_valid=1 id=%0d required no response at t=%0t",
                 bus.rsp_id, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_cycle", DW'(cyc), DW'(mon_e[EXP_W-1 -: 32]));
        chk("rsp_id", DW'(bus.rsp_id), DW'(mon_e[DW+1 +: 8]));
        chk("rsp_we", DW'(bus.rsp_we), DW'(mon_e[DW]));
        if (!mon_e[DW]) last_rd = mon_e[DW-1:0];
        chk("rsp_rdata", bus.rsp_rdata, last_rd);
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL rsp_missing: actual none required id=%0d at cycle %0d",
               mon_e[DW+1 +: 8], mon_e[EXP_W-1 -: 32]);
    end
  end

  // Macro pin protocol: wen is a single-cycle pulse inside an enabled access.
  logic prev_wen = 1'b0;
  int   wen_pulses = 0;
  always @(negedge CLK) begin
    if (sram_wen) begin
      wen_pulses++;
      chk("wen_single_cycle", DW'(prev_wen), DW'(0));
      chk("wen_with_cen", DW'(sram_cen), DW'(0));
      chk("wen_not_ren", DW'(sram_ren), DW'(0));
    end
    prev_wen = sram_wen;
  end

  // ---------------- reference model + driver ----------------
  bit [DW-1:0]       ref_mem [0:2047];
  logic [STIM_W-1:0] stim_q0[$];
  logic [STIM_W-1:0] stim_q1[$];
  int                last_win   = N - 1;
  int                next_free  = 0;
  int                wr_accepts = 0;
  bit                gap_en     = 1'b0;

  function automatic int model_winner(input logic [N-1:0] v, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  task automatic enq(input int id, input logic we, input int addr, input logic [DW-1:0] data);
    logic [STIM_W-1:0] s;
    s = {we, AW'(addr), data};
    if (id == 0) stim_q0.push_back(s);
    else         stim_q1.push_back(s);
  endtask

  // One clock of stimulus: sample at negedge, predict, then drive after posedge.
  task automatic drive_step();
    logic [N-1:0]      vld, rdy, hs, expv;
    logic [STIM_W-1:0] s;
    logic [AW-1:0]     addr;
    logic              we;
    int                w, exp_w, mid;
    @(negedge CLK);
    vld = bus.req_valid;
    rdy = bus.req_ready;
    hs  = vld & rdy;
    chk("ready_onehot", DW'($countones(rdy) <= 1), DW'(1));
    chk("ready_without_valid", DW'(rdy & ~vld), DW'(0));
    exp_w = -1;
    if (cyc < next_free) begin
      chk("ready_while_busy", DW'(rdy), DW'(0));
    end else if (vld != '0) begin
      exp_w = model_winner(vld, last_win);
      expv = '0;
      expv[exp_w] = 1'b1;
      chk("grant", DW'(rdy), DW'(expv));
    end
    w = -1;
    for (int i = 0; i < N; i++) if (hs[i]) w = i;
    if (w >= 0) begin
      mid  = (exp_w >= 0) ? exp_w : w;
      addr = bus.req_addr[mid*AW +: AW];
      we   = bus.req_we[mid];
      if (we) begin
        ref_mem[addr] = bus.req_wdata[mid*DW +: DW];
        push_exp(cyc + 4, mid, 1'b1, '0);
        next_free = cyc + 4;
        wr_accepts++;
      end else begin
        push_exp(cyc + 3, mid, 1'b0, ref_mem[addr]);
        next_free = cyc + 3;
      end
      last_win = mid;
    end
    @(posedge CLK);
    #1;
    if (w >= 0) bus.req_valid[w] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!bus.req_valid[i] && (!gap_en || $urandom_range(0, 3) != 0)) begin
        if (i == 0 && stim_q0.size() > 0) begin
          s = stim_q0.pop_front();
        end else if (i == 1 && stim_q1.size() > 0) begin
          s = stim_q1.pop_front();
        end else begin
          continue;
        end
        bus.req_valid[i]            = 1'b1;
        bus.req_we[i]               = s[STIM_W-1];
        bus.req_addr[i*AW +: AW]    = s[DW +: AW];
        bus.req_wdata[i*DW +: DW]   = s[DW-1:0];
      end
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((stim_q0.size() + stim_q1.size() != 0 || bus.req_valid != '0 || exp_q.size() != 0)
           && n < limit) begin
      drive_step();
      n++;
    end
    chk("drain_done", DW'(n < limit), DW'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cen"}, DW'(sram_cen), DW'(1));
    chk({tag, "_wen"}, DW'(sram_wen), DW'(0));
    chk({tag, "_ren"}, DW'(sram_ren), DW'(0));
    chk({tag, "_a"}, DW'(sram_a), DW'(0));
    chk({tag, "_d"}, sram_d, '0);
    chk({tag, "_rsp_valid"}, DW'(bus.rsp_valid), DW'(0));
    chk({tag, "_rsp_id"}, DW'(bus.rsp_id), DW'(0));
    chk({tag, "_rsp_we"}, DW'(bus.rsp_we), DW'(0));
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, '0);
    chk({tag, "_state"}, DW'(dbg_state), DW'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    RESET_N       = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_vals("reset");
    @(negedge CLK);
    RESET_N = 1'b1;

    // Reset caught in W2: the write to addr 5 must not land.
    @(posedge CLK);
    #1;
    bus.req_valid[0]     = 1'b1;
    bus.req_we[0]        = 1'b1;
    bus.req_addr[0 +: AW] = AW'(5);
    bus.req_wdata[0 +: DW] = DW'('hA5);
    @(negedge CLK);
    chk("t1_ready", DW'(bus.req_ready), DW'(1));
    @(posedge CLK);          // accept edge
    #1;
    bus.req_valid[0] = 1'b0;
    @(posedge CLK);          // into W1
    @(posedge CLK);          // into W2
    #1;
    chk("t1_wen_in_w2", DW'(sram_wen), DW'(1));
    RESET_N = 1'b0;
    #1;
    check_reset_vals("midw2");
    repeat (3) @(posedge CLK);
    #1;
    chk("t1_mem5_unchanged", sram_mem[5], '0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Write then read back on requester 0.
    enq(0, 1'b1, 7, DW'('h1234));
    enq(0, 1'b0, 7, '0);
    drain(200);

    // Both requesters reading back to back.
    for (int k = 0; k < 4; k++) begin
      enq(0, 1'b0, k, '0);
      enq(1, 1'b0, 7 + k, '0);
    end
    drain(200);

    // Address extremes, written back to back then read.
    enq(0, 1'b1, 2047, {$urandom, $urandom, $urandom, $urandom});
    enq(0, 1'b1, 0, {$urandom, $urandom, $urandom, $urandom});
    drain(200);
    enq(1, 1'b0, 2047, '0);
    enq(1, 1'b0, 0, '0);
    drain(200);

    // Read-after-write across requesters at addr 9.
    enq(0, 1'b1, 9, {$urandom, $urandom, $urandom, $urandom});
    drain(200);
    enq(1, 1'b0, 9, '0);
    drain(200);

    // Randomized traffic with idle gaps and colliding addresses.
    gap_en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      for (int r = 0; r < N; r++) begin
        case ($urandom_range(0, 7))
          0:       a = 0;
          1:       a = 2047;
          default: a = $urandom_range(0, 15);
        endcase
        enq(r, 1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
      end
    end
    drain(5000);

    repeat (4) @(negedge CLK);
    chk("wen_pulse_count", DW'(wen_pulses), DW'(wr_accepts));
    for (int k = 0; k < 17; k++) begin
      a = (k == 16) ? 2047 : k;
      chk("mem_final", sram_mem[a], ref_mem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
